// File: rtl/rv_mem_pkg.sv
// rv_mem_pkg: shared types for the IF/MA memory arbiter.
//   arb_state_t : arbiter FSM states
//   owner_t     : which requester owns (or last owned) the memory
//   BE_WORD     : full-word byte enable forced for fetches
package rv_mem_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_IF, ST_MA} arb_state_t;

  typedef enum logic {OWN_IF, OWN_MA} owner_t;

  localparam logic [3:0] BE_WORD = 4'hF;

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the fetch (if_*), data (ma_*) and memory (mem_*) handshakes.
//   slave  : arbiter view (requests/ack in, grants/completions/memory access out)
//   master : environment view (requesters plus memory model)
interface mem_arbiter_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        if_err;

  logic        ma_req;
  logic        ma_we;
  logic [31:0] ma_addr;
  logic [31:0] ma_wdata;
  logic [3:0]  ma_be;
  logic        ma_gnt;
  logic        ma_rvalid;
  logic [31:0] ma_rdata;
  logic        ma_err;

  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    input  ma_req, ma_we, ma_addr, ma_wdata, ma_be,
    input  mem_ack, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output ma_gnt, ma_rvalid, ma_rdata, ma_err,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr,
    output ma_req, ma_we, ma_addr, ma_wdata, ma_be,
    output mem_ack, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  ma_gnt, ma_rvalid, ma_rdata, ma_err,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_wdog.sv
// mem_wdog: access watchdog counter.
//   clk, rst : clock, async active-high reset
//   clr      : synchronous clear (has priority over en)
//   en       : count one cycle
//   expired  : count has reached TIMEOUT-1
module mem_wdog #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch (IF) and data access (MA).
//   clk, rst : clock, async active-high reset
//   bus      : mem_arbiter_if.slave carrying the IF/MA req/gnt handshakes, their
//              completions (rvalid/rdata/err) and the memory req/ack access.
// One access at a time; ties alternate owners; an unacknowledged access is aborted
// after TIMEOUT cycles of mem_req and completed with err.
module mem_arbiter
  import rv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t  state_q, state_d;
  owner_t      last_owner_q, last_owner_d;

  logic        if_gnt_q, if_gnt_d, if_rvalid_q, if_rvalid_d, if_err_q, if_err_d;
  logic [31:0] if_rdata_q, if_rdata_d;
  logic        ma_gnt_q, ma_gnt_d, ma_rvalid_q, ma_rvalid_d, ma_err_q, ma_err_d;
  logic [31:0] ma_rdata_q, ma_rdata_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_be_q, mem_be_d;

  logic        idle;
  logic        expired;

  assign idle = (state_q == ST_IDLE);

  // Counter sits at 0 in idle, so the first busy cycle is count 0.
  mem_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (idle),
    .en      (!idle),
    .expired (expired)
  );

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    if_gnt_d     = 1'b0;
    if_rvalid_d  = 1'b0;
    if_err_d     = 1'b0;
    if_rdata_d   = if_rdata_q;
    ma_gnt_d     = 1'b0;
    ma_rvalid_d  = 1'b0;
    ma_err_d     = 1'b0;
    ma_rdata_d   = ma_rdata_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;

    case (state_q)
      ST_IDLE: begin
        // IF wins when alone, or on a tie when MA owned the previous access.
        if (bus.if_req && (!bus.ma_req || last_owner_q == OWN_MA)) begin
          state_d      = ST_IF;
          last_owner_d = OWN_IF;
          if_gnt_d     = 1'b1;
          mem_we_d     = 1'b0;
          mem_addr_d   = bus.if_addr;
          mem_wdata_d  = '0;
          mem_be_d     = BE_WORD;
        end else if (bus.ma_req) begin
          state_d      = ST_MA;
          last_owner_d = OWN_MA;
          ma_gnt_d     = 1'b1;
          mem_we_d     = bus.ma_we;
          mem_addr_d   = bus.ma_addr;
          mem_wdata_d  = bus.ma_wdata;
          mem_be_d     = bus.ma_be;
        end
      end
      ST_IF: begin
        // Ack is tested first so it wins over a simultaneous timeout.
        if (bus.mem_ack) begin
          state_d     = ST_IDLE;
          if_rvalid_d = 1'b1;
          if_rdata_d  = bus.mem_rdata;
        end else if (expired) begin
          state_d     = ST_IDLE;
          if_rvalid_d = 1'b1;
          if_rdata_d  = '0;
          if_err_d    = 1'b1;
        end
      end
      ST_MA: begin
        if (bus.mem_ack) begin
          state_d     = ST_IDLE;
          ma_rvalid_d = 1'b1;
          ma_rdata_d  = mem_we_q ? 32'h0 : bus.mem_rdata;
        end else if (expired) begin
          state_d     = ST_IDLE;
          ma_rvalid_d = 1'b1;
          ma_rdata_d  = '0;
          ma_err_d    = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      last_owner_q <= OWN_IF;
      if_gnt_q     <= 1'b0;
      if_rvalid_q  <= 1'b0;
      if_err_q     <= 1'b0;
      if_rdata_q   <= '0;
      ma_gnt_q     <= 1'b0;
      ma_rvalid_q  <= 1'b0;
      ma_err_q     <= 1'b0;
      ma_rdata_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      if_gnt_q     <= if_gnt_d;
      if_rvalid_q  <= if_rvalid_d;
      if_err_q     <= if_err_d;
      if_rdata_q   <= if_rdata_d;
      ma_gnt_q     <= ma_gnt_d;
      ma_rvalid_q  <= ma_rvalid_d;
      ma_err_q     <= ma_err_d;
      ma_rdata_q   <= ma_rdata_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
    end
  end

  assign bus.if_gnt    = if_gnt_q;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_err    = if_err_q;
  assign bus.ma_gnt    = ma_gnt_q;
  assign bus.ma_rvalid = ma_rvalid_q;
  assign bus.ma_rdata  = ma_rdata_q;
  assign bus.ma_err    = ma_err_q;
  // Decoded from the state flop so reset drops it without a clock edge.
  assign bus.mem_req   = !idle;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus for mem_arbiter with a transaction-level model
// predicting grants, completions and memory activity, plus literal spot checks.
module tb_mem_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: ack on the ack_wait-th cycle of mem_req (0 = never ack).
  int          ack_wait  = 1;
  int          hc        = 0;
  logic [31:0] rdata_val = 32'h0;
  assign bus.mem_rdata = rdata_val;

  // Model state: whether an access is in flight, who owns it, how long mem_req
  // has been high, and the payload the memory should see.
  bit          m_busy;
  int          m_owner;
  int          m_last;
  int          m_held;
  logic        m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  // Expectations for the interval after the next rising edge.
  logic        e_if_gnt, e_ma_gnt, e_if_rv, e_ma_rv, e_err, e_mem_req;
  logic [31:0] e_rdata;

  // Observation logs for the directed literal checks.
  int grants[$];
  int req_cycles   = 0;
  int last_req_len = 0;
  int rv_count     = 0;

  always @(negedge clk) begin
    if (rst) begin
      m_busy = 0; m_last = 0; m_held = 0;
      e_if_gnt = 0; e_ma_gnt = 0; e_if_rv = 0; e_ma_rv = 0; e_err = 0; e_mem_req = 0;
      e_rdata = '0;
      hc = 0;
      bus.mem_ack = 1'b0;
      req_cycles = 0;
    end else begin
      check("if_gnt", bus.if_gnt, e_if_gnt);
      check("ma_gnt", bus.ma_gnt, e_ma_gnt);
      check("if_rvalid", bus.if_rvalid, e_if_rv);
      check("ma_rvalid", bus.ma_rvalid, e_ma_rv);
      check("mem_req", bus.mem_req, e_mem_req);
      if (e_if_rv) begin
        check("if_rdata", bus.if_rdata, e_rdata);
        check("if_err", bus.if_err, e_err);
      end
      if (e_ma_rv) begin
        check("ma_rdata", bus.ma_rdata, e_rdata);
        check("ma_err", bus.ma_err, e_err);
      end
      if (e_mem_req) begin
        check("mem_we", bus.mem_we, m_we);
        check("mem_addr", bus.mem_addr, m_addr);
        check("mem_be", bus.mem_be, m_be);
        if (m_we) check("mem_wdata", bus.mem_wdata, m_wdata);
      end

      if (bus.if_gnt) grants.push_back(0);
      if (bus.ma_gnt) grants.push_back(1);
      if (bus.if_rvalid || bus.ma_rvalid) rv_count++;
      if (bus.mem_req) begin
        req_cycles++;
      end else if (req_cycles != 0) begin
        last_req_len = req_cycles;
        req_cycles   = 0;
      end

      hc = bus.mem_req ? hc + 1 : 0;
      bus.mem_ack = bus.mem_req && ack_wait != 0 && hc == ack_wait;

      e_if_gnt = 0; e_ma_gnt = 0; e_if_rv = 0; e_ma_rv = 0; e_err = 0;
      if (!m_busy) begin
        if (bus.if_req || bus.ma_req) begin
          if (bus.if_req && bus.ma_req) m_owner = 1 - m_last;
          else                          m_owner = bus.ma_req ? 1 : 0;
          m_last = m_owner;
          m_busy = 1;
          m_held = 0;
          if (m_owner == 0) begin
            m_we = 1'b0; m_addr = bus.if_addr; m_be = 4'hF; m_wdata = '0;
            e_if_gnt = 1;
          end else begin
            m_we = bus.ma_we; m_addr = bus.ma_addr; m_be = bus.ma_be; m_wdata = bus.ma_wdata;
            e_ma_gnt = 1;
          end
        end
      end else begin
        m_held++;
        if (bus.mem_ack) begin
          e_rdata = m_we ? 32'h0 : bus.mem_rdata;
          e_err   = 0;
          m_busy  = 0;
          if (m_owner == 0) e_if_rv = 1; else e_ma_rv = 1;
        end else if (m_held == TIMEOUT) begin
          e_rdata = 32'h0;
          e_err   = 1;
          m_busy  = 0;
          if (m_owner == 0) e_if_rv = 1; else e_ma_rv = 1;
        end
      end
      e_mem_req = m_busy;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic wait_rv(input bit ma, input string nm);
    int n = 0;
    while (!(ma ? bus.ma_rvalid : bus.if_rvalid) && n < 60) begin
      tick();
      n++;
    end
    check(nm, ma ? bus.ma_rvalid : bus.if_rvalid, 1'b1);
  endtask

  int g_base;
  int rv_base;
  int exp_order[6] = '{1, 0, 1, 0, 1, 0};

  initial begin
    rst          = 1'b1;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ma_req   = 1'b0;
    bus.ma_we    = 1'b0;
    bus.ma_addr  = '0;
    bus.ma_wdata = '0;
    bus.ma_be    = '0;
    do_reset();

    // Reset values.
    check("rst_mem_req", bus.mem_req, 1'b0);
    check("rst_mem_be", bus.mem_be, 4'h0);
    check("rst_mem_addr", bus.mem_addr, 32'h0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);

    // Fetch with a zero-wait memory.
    ack_wait    = 1;
    rdata_val   = 32'h0050_0093;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    tick();
    check("t1_if_gnt", bus.if_gnt, 1'b1);
    check("t1_mem_addr", bus.mem_addr, 32'h100);
    check("t1_mem_be", bus.mem_be, 4'hF);
    check("t1_mem_we", bus.mem_we, 1'b0);
    bus.if_req = 1'b0;
    tick();
    check("t1_if_rvalid", bus.if_rvalid, 1'b1);
    check("t1_if_rdata", bus.if_rdata, 32'h0050_0093);
    check("t1_if_err", bus.if_err, 1'b0);
    tick();

    // Tie after reset: grants alternate starting with MA.
    do_reset();
    g_base      = grants.size();
    bus.if_addr = 32'h200;
    bus.ma_addr = 32'h1000;
    bus.ma_we   = 1'b0;
    bus.ma_be   = 4'hF;
    bus.if_req  = 1'b1;
    bus.ma_req  = 1'b1;
    for (int n = 0; n < 100 && grants.size() < g_base + 6; n++) tick();
    bus.if_req = 1'b0;
    bus.ma_req = 1'b0;
    check("t2_ngrants", grants.size() - g_base, 6);
    for (int i = 0; i < 6; i++) begin
      if (grants.size() > g_base + i) check("t2_order", grants[g_base + i], exp_order[i]);
    end
    tick(); tick();

    // Store with a 3-cycle memory; payload changed after grant must not leak.
    ack_wait     = 3;
    rdata_val    = 32'h1234_5678;
    bus.ma_we    = 1'b1;
    bus.ma_addr  = 32'h2004;
    bus.ma_wdata = 32'hDEAD_BEEF;
    bus.ma_be    = 4'b0011;
    bus.ma_req   = 1'b1;
    tick();
    check("t3_ma_gnt", bus.ma_gnt, 1'b1);
    check("t3_mem_we", bus.mem_we, 1'b1);
    check("t3_mem_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
    check("t3_mem_be", bus.mem_be, 4'b0011);
    bus.ma_req   = 1'b0;
    bus.ma_addr  = 32'hFFFF_FFFC;
    bus.ma_wdata = 32'h0;
    wait_rv(1'b1, "t3_ma_rvalid");
    check("t3_ma_rdata", bus.ma_rdata, 32'h0);
    tick();
    check("t3_req_len", last_req_len, 3);

    // Memory never acks: abort after TIMEOUT cycles, then normal service.
    ack_wait    = 0;
    bus.if_addr = 32'h300;
    bus.if_req  = 1'b1;
    tick();
    bus.if_req = 1'b0;
    wait_rv(1'b0, "t4_if_rvalid");
    check("t4_if_err", bus.if_err, 1'b1);
    check("t4_if_rdata", bus.if_rdata, 32'h0);
    tick();
    check("t4_req_len", last_req_len, 16);
    ack_wait    = 2;
    rdata_val   = 32'hCAFE_F00D;
    bus.if_addr = 32'h304;
    bus.if_req  = 1'b1;
    tick();
    bus.if_req = 1'b0;
    wait_rv(1'b0, "t4b_if_rvalid");
    check("t4b_if_rdata", bus.if_rdata, 32'hCAFE_F00D);
    check("t4b_if_err", bus.if_err, 1'b0);
    tick();

    // Ack exactly on the timeout cycle: ack wins.
    ack_wait    = 16;
    rdata_val   = 32'h0BAD_F00D;
    bus.ma_we   = 1'b0;
    bus.ma_addr = 32'h40;
    bus.ma_be   = 4'hF;
    bus.ma_req  = 1'b1;
    tick();
    bus.ma_req = 1'b0;
    wait_rv(1'b1, "t5_ma_rvalid");
    check("t5_ma_err", bus.ma_err, 1'b0);
    check("t5_ma_rdata", bus.ma_rdata, 32'h0BAD_F00D);
    tick();
    check("t5_req_len", last_req_len, 16);

    // Reset during the second wait cycle of an access.
    ack_wait    = 0;
    bus.if_addr = 32'h500;
    bus.if_req  = 1'b1;
    tick();
    bus.if_req = 1'b0;
    tick();
    check("t6_busy", bus.mem_req, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("t6_mem_req", bus.mem_req, 1'b0);
    check("t6_mem_addr", bus.mem_addr, 32'h0);
    check("t6_mem_be", bus.mem_be, 4'h0);
    check("t6_if_gnt", bus.if_gnt, 1'b0);
    check("t6_if_rvalid", bus.if_rvalid, 1'b0);
    check("t6_ma_rdata", bus.ma_rdata, 32'h0);
    tick();
    tick();
    rv_base = rv_count;
    rst = 1'b0;
    for (int n = 0; n < 20; n++) tick();
    check("t6_no_rvalid", rv_count - rv_base, 0);
    ack_wait    = 1;
    g_base      = grants.size();
    bus.if_req  = 1'b1;
    bus.ma_req  = 1'b1;
    for (int n = 0; n < 20 && grants.size() <= g_base; n++) tick();
    bus.if_req = 1'b0;
    bus.ma_req = 1'b0;
    check("t6_ngrants", grants.size() > g_base, 1'b1);
    if (grants.size() > g_base) check("t6_first_tie", grants[g_base], 1);
    for (int n = 0; n < 6; n++) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port instruction/data memory between the fetch stage (IF) and the memory-access stage (MA) of the rv32 core. It accepts one request at a time over a req/gnt handshake and drives the memory over a req/ack handshake. It returns completion (read data or write done) to the owning requester and aborts any access the memory fails to acknowledge within a bounded time. It sits between the IF/MA units and the memory model, replacing their separate memory ports.

## Interface
- `TIMEOUT`, 16: max cycles mem_req is held without mem_ack before abort (≥2)
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `if_req` in 1: fetch request, held until `if_gnt`
- `if_addr` in 32: fetch byte address
- `if_gnt` out 1: one-cycle pulse, fetch request accepted
- `if_rvalid` out 1: one-cycle pulse, fetch complete
- `if_rdata` out 32: fetched word, valid with `if_rvalid`
- `if_err` out 1: valid with `if_rvalid`, access timed out
- `ma_req` in 1: data request, held until `ma_gnt`
- `ma_we` in 1: 1 = store, 0 = load
- `ma_addr` in 32: data byte address
- `ma_wdata` in 32: store data
- `ma_be` in 4: byte enables
- `ma_gnt`, `ma_rvalid`, `ma_rdata`(32), `ma_err`: as fetch-side equivalents
- `mem_req` out 1: memory access active
- `mem_we`, `mem_addr`(32), `mem_wdata`(32), `mem_be`(4) out: latched payload; fetch forces we=0, be=4'hF
- `mem_ack` in 1: memory done; read data valid same cycle
- `mem_rdata` in 32: memory read data

## Operation
- States: ST_IDLE, ST_IF, ST_MA.
- ST_IDLE: if exactly one req is high, go to that owner's state. If both are high, pick the owner not in `last_owner`. In all cases, latch the payload, set `last_owner`, and register a `*_gnt` pulse.
- ST_IF/ST_MA: `mem_req`=1 with the latched payload. The watchdog counts cycles in state, starting at 0.
  - On `mem_ack`: register `*_rvalid`=1, `*_rdata`=`mem_rdata` (0 for stores), `*_err`=0, then go to ST_IDLE.
  - On count = TIMEOUT-1 without ack: register `*_rvalid`=1, `*_rdata`=0, `*_err`=1, then go to ST_IDLE.
  - If ack and timeout occur in the same cycle, ack wins.
- Requests arriving while busy are ignored until ST_IDLE; requesters keep req asserted.
- Payload changes after gnt have no effect.
- Reset values:
  - state ST_IDLE; `last_owner` = IF, so MA wins the first tie
  - all gnt/rvalid/err outputs 0
  - `mem_req` and `mem_we` 0; `mem_be`, `mem_addr`, `mem_wdata` 0
  - rdata outputs 0; counter 0
- Reset mid-access: `mem_req` drops asynchronously. No rvalid is issued for the aborted access.

## Timing
- Cycle N: req seen in ST_IDLE. N+1: `*_gnt`=1, `mem_req`=1.
- Ack in cycle M gives `*_rvalid` in M+1, with state back at ST_IDLE in M+1.
- A new grant is possible at M+2 at the earliest.
- Zero-wait memory (ack at N+1): access latency is 2 cycles, from req to rvalid.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles (N+1..N+TIMEOUT); `*_rvalid` with err follows at N+TIMEOUT+1.
- All outputs are registered; there are no combinational in→out paths.
- Fairness: under continuous requests from both sides, grants strictly alternate.

## Structure
- Package `rv_mem_pkg` holds:
  - `typedef enum logic [1:0] {ST_IDLE, ST_IF, ST_MA} arb_state_t`
  - `typedef enum logic {OWN_IF, OWN_MA} owner_t`
  - `localparam BE_WORD = 4'hF`
- Sub-module `mem_wdog`: a `$clog2(TIMEOUT)`-bit counter with `clr`/`en` inputs and an `expired` output (count == TIMEOUT-1). All other logic lives in a single FSM.

## Test plan
- Reset, then fetch only, `if_addr`=0x100, memory acks 1 cycle after `mem_req`:
  - `if_gnt` pulses at N+1
  - `mem_addr`=0x100, `mem_be`=F, `mem_we`=0
  - `if_rvalid` at N+2, `if_rdata`=`mem_rdata`=0x00500093, `if_err`=0
- Tie right after reset, both req high: MA is granted first, IF is granted at the next ST_IDLE. Holding both high for 6 accesses gives grants MA,IF,MA,IF,MA,IF.
- Store, `ma_we`=1, `ma_addr`=0x2004, `ma_wdata`=0xDEADBEEF, `ma_be`=4'b0011, 3-cycle memory wait:
  - memory-side fields match the request
  - `mem_req` is high 3 cycles
  - `ma_rvalid` arrives with `ma_rdata`=0
- Memory never acks, TIMEOUT=16:
  - `mem_req` is high exactly 16 cycles
  - then `if_rvalid`=1, `if_err`=1, `if_rdata`=0
  - the next request is served normally
- Ack arrives on the timeout cycle (cycle 16): completion with err=0 and valid data.
- `rst` asserted mid-access (cycle 2 of wait):
  - `mem_req` and all outputs go to 0 without waiting for a clock edge
  - no rvalid is issued
  - after release, the first tie again grants MA
